// File: rtl/minx_pkg.sv
// Shared definitions for the minx peripheral blocks.
// Register map, bit positions and the EEPROM master FSM states.
package minx_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_CLKDIV = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_WRITE    = 1;
    localparam int CTRL_READ     = 2;
    localparam int CTRL_STOP     = 3;
    localparam int CTRL_ACK_SEND = 4;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_RX_ACK = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } eeprom_master_state_t;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit tick generator for the I2C master.
// Reloads while held so the first tick lands div+1 cycles after release.
module i2c_quarter_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (hold || count == 8'd0) begin
            count <= div;
        end else begin
            count <= count - 8'd1;
        end
    end

    assign tick = !hold && (count == 8'd0);

endmodule

// File: rtl/eeprom_master.sv
// Autonomous I2C initiator for the save EEPROM.
// Runs START / byte / ACK / STOP sequences from a 4-byte register window.
module eeprom_master
    import minx_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = 24'h20F0,
    parameter logic [7:0]  DIV_RESET = 8'h0F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic        sda_in,
    output logic        scl_out,
    output logic        sda_out,
    output logic        irq
);

    eeprom_master_state_t state, state_d;

    logic [1:0] q;
    logic [2:0] bit_cnt;
    logic [7:0] sh;
    logic       rx_bit;
    logic [7:0] data_q;
    logic [7:0] clkdiv_q;
    logic       rx_ack;
    logic       cmd_write;
    logic       cmd_read;
    logic       cmd_stop;
    logic       ack_send;
    logic       scl_hold;
    logic       sda_hold;
    logic       scl_c;
    logic       sda_c;
    logic       tick;
    logic       busy;
    logic       in_win;
    logic [1:0] off;
    logic       wr_ok;
    logic       has_op;
    logic       last_q;

    assign in_win = bus_address_in[23:2] == BASE_ADDR[23:2];
    assign off    = bus_address_in[1:0];
    assign busy   = state != ST_IDLE;
    assign wr_ok  = bus_write && in_win && !busy;
    assign has_op = |bus_data_in[CTRL_STOP:CTRL_START];
    assign last_q = tick && (q == 2'd3);

    i2c_quarter_tick u_tick (
        .clk   (clk),
        .reset (reset),
        .hold  (state == ST_IDLE),
        .div   (clkdiv_q),
        .tick  (tick)
    );

    always_comb begin
        state_d = state;
        scl_c   = scl_hold;
        sda_c   = sda_hold;
        irq     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (wr_ok && off == REG_CTRL && has_op) begin
                    if (bus_data_in[CTRL_START])
                        state_d = ST_START;
                    else if (bus_data_in[CTRL_WRITE] || bus_data_in[CTRL_READ])
                        state_d = ST_BIT;
                    else
                        state_d = ST_STOP;
                end
            end
            ST_START: begin
                scl_c = q < 2'd2;
                sda_c = q == 2'd0;
                if (last_q) begin
                    if (cmd_write || cmd_read)
                        state_d = ST_BIT;
                    else if (cmd_stop)
                        state_d = ST_STOP;
                    else
                        state_d = ST_DONE;
                end
            end
            ST_BIT: begin
                scl_c = (q == 2'd1) || (q == 2'd2);
                sda_c = cmd_write ? sh[7] : 1'b1;
                if (last_q && bit_cnt == 3'd7)
                    state_d = ST_ACK;
            end
            ST_ACK: begin
                scl_c = (q == 2'd1) || (q == 2'd2);
                sda_c = cmd_write ? 1'b1 : ack_send;
                if (last_q)
                    state_d = cmd_stop ? ST_STOP : ST_DONE;
            end
            ST_STOP: begin
                scl_c = q != 2'd0;
                sda_c = q >= 2'd2;
                if (last_q)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                irq     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lines come straight from state so reset releases them asynchronously.
    assign scl_out = scl_c;
    assign sda_out = sda_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            q         <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            rx_bit    <= 1'b0;
            data_q    <= '0;
            clkdiv_q  <= DIV_RESET;
            rx_ack    <= 1'b0;
            cmd_write <= 1'b0;
            cmd_read  <= 1'b0;
            cmd_stop  <= 1'b0;
            ack_send  <= 1'b0;
            scl_hold  <= 1'b1;
            sda_hold  <= 1'b1;
        end else begin
            state    <= state_d;
            scl_hold <= scl_c;
            sda_hold <= sda_c;
            if (state == ST_IDLE)
                q <= '0;
            else if (tick)
                q <= q + 2'd1;
            if (wr_ok) begin
                unique case (off)
                    REG_CTRL: begin
                        if (has_op) begin
                            cmd_write <= bus_data_in[CTRL_WRITE];
                            cmd_read  <= bus_data_in[CTRL_READ] &&
                                         !bus_data_in[CTRL_WRITE];
                            cmd_stop  <= bus_data_in[CTRL_STOP];
                            ack_send  <= bus_data_in[CTRL_ACK_SEND];
                            sh        <= data_q;
                            bit_cnt   <= '0;
                        end
                    end
                    REG_DATA:   data_q   <= bus_data_in;
                    REG_CLKDIV: clkdiv_q <= bus_data_in;
                    default: ;
                endcase
            end
            if (tick && state == ST_BIT) begin
                if (q == 2'd1)
                    rx_bit <= sda_in;
                if (q == 2'd3) begin
                    sh      <= {sh[6:0], rx_bit};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
            if (tick && state == ST_ACK) begin
                if (q == 2'd1 && cmd_write)
                    rx_ack <= sda_in;
                if (q == 2'd3 && cmd_read)
                    data_q <= sh;
            end
        end
    end

    always_comb begin
        bus_data_out = '0;
        if (bus_read && in_win) begin
            unique case (off)
                REG_STATUS: begin
                    bus_data_out[STAT_BUSY]   = busy;
                    bus_data_out[STAT_RX_ACK] = rx_ack;
                end
                REG_DATA:   bus_data_out = data_q;
                REG_CLKDIV: bus_data_out = clkdiv_q;
                default:    bus_data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_master.sv
// Directed bench for eeprom_master with a small bit-level I2C responder.
// Expected values are hand-derived from the register map and phase timing.
module tb_eeprom_master;

    localparam logic [23:0] A_CTRL   = 24'h20F0;
    localparam logic [23:0] A_STATUS = 24'h20F1;
    localparam logic [23:0] A_DATA   = 24'h20F2;
    localparam logic [23:0] A_CLKDIV = 24'h20F3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic [23:0] bus_address_in = '0;
    logic [7:0]  bus_data_in = '0;
    logic [7:0]  bus_data_out;
    logic        sda_in;
    logic        scl_out;
    logic        sda_out;
    logic        irq;

    logic        sda_slv = 1'b1;
    logic        sda_line;
    logic        slv_read = 1'b0;
    logic        ack_en = 1'b1;
    logic [7:0]  rd_byte = '0;
    int          slv_base = 0;

    int          n_chk = 0;
    int          n_err = 0;
    int          nrise = 0;
    int          n_start = 0;
    int          n_stop = 0;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        rec [0:1023];
    logic        busy_log [0:255];

    assign sda_line = sda_out & sda_slv;
    assign sda_in   = sda_line;

    eeprom_master dut (
        .clk            (clk),
        .reset          (reset),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .sda_in         (sda_in),
        .scl_out        (scl_out),
        .sda_out        (sda_out),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (scl_out && !prev_scl) begin
            if (nrise < 1024)
                rec[nrise] = sda_line;
            nrise++;
        end
        if (scl_out && prev_scl && prev_sda && !sda_line)
            n_start++;
        if (scl_out && prev_scl && !prev_sda && sda_line)
            n_stop++;
        prev_scl = scl_out;
        prev_sda = sda_line;
    end

    always @(negedge scl_out) begin
        int k;
        k = nrise - slv_base;
        if (slv_read)
            sda_slv = (k < 8) ? rd_byte[7-k] : 1'b1;
        else
            sda_slv = (k == 8) ? !ack_en : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_read       = 1'b0;
        bus_address_in = a;
        bus_data_in    = d;
        bus_write      = 1'b1;
        @(posedge clk);
        #1;
        bus_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [23:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_address_in = a;
        bus_read       = 1'b1;
        #1;
        d        = bus_data_out;
        bus_read = 1'b0;
    endtask

    // Issues a CTRL write, then watches STATUS.BUSY and irq per cycle.
    task automatic run_cmd(input logic [7:0] c, input int maxc,
                           output int at, output int n_irq);
        at    = 0;
        n_irq = 0;
        bus_wr(A_CTRL, c);
        bus_address_in = A_STATUS;
        bus_read       = 1'b1;
        for (int n = 1; n <= maxc; n++) begin
            @(negedge clk);
            busy_log[n] = bus_data_out[0];
            if (irq) begin
                n_irq++;
                if (at == 0)
                    at = n;
            end
        end
        bus_read = 1'b0;
    endtask

    function automatic logic [7:0] line_byte(input int b);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            v = {v[6:0], rec[b+i]};
        return v;
    endfunction

    initial begin
        logic [7:0] d;
        int at, ni, b0, s0, wc, icnt;
        logic ok;

        repeat (3) @(negedge clk);
        chk("rst_scl", scl_out, 1);
        chk("rst_sda", sda_out, 1);
        chk("rst_irq", irq, 0);
        reset = 1'b1;
        bus_rd(A_CLKDIV, d);  chk("rst_clkdiv", d, 8'h0F);
        bus_rd(A_STATUS, d);  chk("rst_status", d, 8'h00);
        bus_rd(A_DATA, d);    chk("rst_data", d, 8'h00);
        bus_rd(24'h2060, d);  chk("rst_outside", d, 8'h00);

        bus_wr(A_CLKDIV, 8'h00);
        bus_wr(A_DATA, 8'hA0);
        bus_rd(A_CLKDIV, d);  chk("clkdiv_wr", d, 8'h00);
        bus_rd(A_DATA, d);    chk("data_wr", d, 8'hA0);

        slv_read = 1'b0; ack_en = 1'b1;
        b0 = nrise; slv_base = nrise; s0 = n_stop;
        run_cmd(8'h0B, 60, at, ni);
        chk("wr_irq_cycle", at, 45);
        chk("wr_irq_count", ni, 1);
        ok = 1'b1;
        for (int n = 1; n <= 45; n++)
            ok = ok & busy_log[n];
        chk("wr_busy_1_45", ok, 1);
        chk("wr_busy_46", busy_log[46], 0);
        chk("wr_rises", nrise - b0, 10);
        chk("wr_line_byte", line_byte(b0), 8'hA0);
        chk("wr_stop", n_stop - s0, 1);
        bus_rd(A_STATUS, d);  chk("wr_status_ack", d, 8'h00);
        chk("wr_idle_scl", scl_out, 1);
        chk("wr_idle_sda", sda_out, 1);

        ack_en = 1'b0;
        slv_base = nrise;
        run_cmd(8'h0B, 60, at, ni);
        chk("nack_irq_cycle", at, 45);
        bus_rd(A_STATUS, d);  chk("nack_status", d, 8'h02);

        slv_read = 1'b1; rd_byte = 8'h5A; ack_en = 1'b1;
        b0 = nrise; slv_base = nrise; s0 = n_stop;
        run_cmd(8'h1C, 60, at, ni);
        chk("rd_irq_cycle", at, 41);
        chk("rd_irq_count", ni, 1);
        chk("rd_line_byte", line_byte(b0), 8'h5A);
        chk("rd_ack_slot", rec[b0+8], 1);
        chk("rd_stop", n_stop - s0, 1);
        bus_rd(A_DATA, d);    chk("rd_data", d, 8'h5A);
        bus_rd(A_STATUS, d);  chk("rd_status", d, 8'h02);

        slv_read = 1'b0;
        run_cmd(8'h10, 20, at, ni);
        chk("noop_irq", ni, 0);
        ok = 1'b0;
        for (int n = 1; n <= 20; n++)
            ok = ok | busy_log[n];
        chk("noop_busy", ok, 0);

        slv_base = nrise; s0 = n_stop; b0 = n_start;
        bus_wr(A_CTRL, 8'h01);
        wc = cyc_now();
        bus_wr(A_CTRL, 8'h08);
        bus_wr(A_DATA, 8'h33);
        bus_wr(A_CLKDIV, 8'h05);
        at = 0; icnt = 0;
        for (int n = 4; n <= 20; n++) begin
            @(negedge clk);
            if (irq) begin
                icnt++;
                if (at == 0)
                    at = n;
            end
        end
        chk("busy_irq_cycle", at, 5);
        chk("busy_irq_count", icnt, 1);
        chk("busy_start", n_start - b0, 1);
        chk("busy_no_stop", n_stop - s0, 0);
        chk("busy_scl_low", scl_out, 0);
        chk("busy_sda_low", sda_out, 0);
        bus_rd(A_DATA, d);    chk("busy_data_kept", d, 8'h5A);
        bus_rd(A_CLKDIV, d);  chk("busy_div_kept", d, 8'h00);
        s0 = n_stop;
        run_cmd(8'h08, 12, at, ni);
        chk("stop_irq_cycle", at, 5);
        chk("stop_seen", n_stop - s0, 1);
        chk("stop_scl", scl_out, 1);
        chk("stop_sda", sda_out, 1);
        if (wc < 0)
            $display("cycle counter wrapped");

        bus_wr(A_DATA, 8'h00);
        bus_wr(A_CTRL, 8'h0B);
        repeat (20) @(negedge clk);
        chk("mid_pre_scl", scl_out, 0);
        chk("mid_pre_sda", sda_out, 0);
        reset = 1'b0;
        #1;
        chk("mid_scl", scl_out, 1);
        chk("mid_sda", sda_out, 1);
        icnt = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (irq)
                icnt++;
        end
        reset = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (irq)
                icnt++;
        end
        chk("mid_no_irq", icnt, 0);
        bus_rd(A_STATUS, d);  chk("mid_status", d, 8'h00);
        bus_rd(A_CLKDIV, d);  chk("mid_clkdiv", d, 8'h0F);

        bus_wr(A_CLKDIV, 8'h00);
        bus_wr(A_DATA, 8'hC3);
        ack_en = 1'b1;
        b0 = nrise; slv_base = nrise;
        run_cmd(8'h0B, 60, at, ni);
        chk("post_irq_cycle", at, 45);
        chk("post_line_byte", line_byte(b0), 8'hC3);
        bus_rd(A_STATUS, d);  chk("post_status", d, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cyc_now();
        return cyc;
    endfunction

endmodule

// File: doc/eeprom_master.md
# eeprom_master

Hardware I2C initiator that drives the save EEPROM's SCL/SDA lines, the controller-side counterpart of the `eeprom` responder. Today the CPU bit-bangs those lines through the GPIO registers at 0x2060/0x2061. This block instead executes START / byte / ACK / STOP sequences autonomously from a small register file on the CPU bus. It sits beside `timer`, `rtc` and `irq` in `minx`. Its `bus_data_out` is OR-ed into the register read mux, and its `irq` feeds the `irq` block.

## Interface
- `BASE_ADDR`, 24'h20F0: base of the 4-byte register window.
- `DIV_RESET`, 8'h0F: reset value of CLKDIV.
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `bus_write` in 1: CPU write strobe.
- `bus_read` in 1: CPU read strobe.
- `bus_address_in` in 24: bus address.
- `bus_data_in` in 8: write data.
- `bus_data_out` out 8: register read data; 0 when the address is outside the window.
- `sda_in` in 1: sampled SDA line (responder `data_out` AND master drive).
- `scl_out` out 1: SCL, open-drain style (1 = released).
- `sda_out` out 1: SDA drive (1 = released).
- `irq` out 1: one-cycle pulse when a command completes.

## Operation
- Registers (offset from BASE_ADDR):
  - +0 CTRL, write-only; reads 0. bit0 START, bit1 WRITE, bit2 READ, bit3 STOP, bit4 ACK_SEND (bit value driven in a READ's ACK slot; 1 = NACK).
  - +1 STATUS, read-only. bit0 BUSY, bit1 RX_ACK (SDA sampled in the last WRITE ACK slot; 0 = acked). Other bits 0.
  - +2 DATA. Write sets the TX byte; read returns the last RX byte.
  - +3 CLKDIV, R/W. Quarter-period = CLKDIV+1 clk cycles.
- Write to CTRL with BUSY=0:
  - Latches the command and sets BUSY.
  - Executes phases in order: START (if set), then BYTE (WRITE if set, else READ if set), then STOP (if set).
  - WRITE has priority over READ when both are set.
  - A CTRL value with none of START/WRITE/READ/STOP set is a no-op: BUSY stays 0 and no irq.
- Ignored while BUSY=1: writes to CTRL, DATA and CLKDIV.
- FSM states: IDLE, START, BIT, ACK, STOP, DONE. Every non-IDLE state except DONE spends 4 quarter ticks (q0–q3).
  - START: q0 SCL=1 SDA=1; q1 SCL=1 SDA=0; q2–q3 SCL=0 SDA=0.
  - BIT (8 bits, MSB first; 3-bit counter): q0 SCL=0, SDA=tx bit (or 1 for READ); q1–q2 SCL=1; q3 SCL=0. SDA is sampled at the q1→q2 tick.
  - ACK: same framing as BIT. SDA=1 for WRITE, or ACK_SEND for READ. For WRITE, the sample goes to RX_ACK.
  - STOP: q0 SCL=0 SDA=0; q1 SCL=1 SDA=0; q2–q3 SCL=1 SDA=1.
  - DONE: one clk. Pulses irq, clears BUSY, returns to IDLE.
- Divider:
  - Free-running down-counter, reloaded with CLKDIV on each tick.
  - Held reloaded while in IDLE, so the first tick comes CLKDIV+1 cycles after the CTRL write.
- No clock stretching and no arbitration; `scl_out` is never read back.

## Timing
- Reset values: `scl_out`=1, `sda_out`=1, `irq`=0, `bus_data_out`=0, BUSY=0, RX_ACK=0, DATA=0, CLKDIV=DIV_RESET, FSM=IDLE.
- BUSY reads 1 starting the cycle after the CTRL write.
- Phase lengths in ticks: START=4, BYTE=36 (8×4 + ACK 4), STOP=4.
- Full START+WRITE+STOP with CLKDIV=0: 44 ticks after the write, then DONE. `irq` is high exactly once, 45 cycles after the write edge. BUSY reads 0 on the cycle after `irq`.
- `bus_data_out` is combinational from `bus_address_in` and the registers; a read of STATUS shows BUSY in the same cycle.
- Reset asserted mid-transfer: lines are released immediately (asynchronously). No STOP is generated and no irq fires.
- CTRL write and DONE in the same cycle: BUSY is still 1, so the write is ignored.

## Structure
- Shared package `minx_pkg` holds:
  - Register offset localparams (CTRL/STATUS/DATA/CLKDIV).
  - CTRL/STATUS bit indices.
  - The `eeprom_master_state_t` enum.
- One sub-module, `i2c_quarter_tick`: the divider with reload, hold-in-idle, and a 1-cycle tick output.
- Everything else lives in `eeprom_master`: register file, FSM, shift register and line drivers.

## Test plan
- **Reset:** after reset, `scl_out`=1, `sda_out`=1, CLKDIV reads 0x0F, STATUS reads 0x00, and reading 0x2060 gives `bus_data_out`=0.
- **Addressed write:** CLKDIV=0, DATA=0xA0, CTRL=0x0B, with the `eeprom` model attached. SDA at the 8 SCL rises is 1,0,1,0,0,0,0,0. RX_ACK=0. `irq` is a single pulse at cycle 45; BUSY is 1 during cycles 1–45.
- **NACK:** same command with the responder's CE low (no ACK) → STATUS reads 0x02 after completion.
- **Read:** CTRL=0x1C with the responder returning 0x5A → DATA reads 0x5A. SDA is released (1) during the 9th SCL-high window, and a STOP follows.
- **Writes while busy:** CTRL=0x01 then CTRL=0x08 one cycle later → only the START is executed. A DATA write while busy leaves DATA unchanged.
- **Reset mid-transfer:** assert reset during bit 3 of a WRITE → `scl_out`=`sda_out`=1 in the same cycle, BUSY=0, no `irq`. A new command after reset release works normally.
